// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port memory.
// One access in flight at a time: IDLE (grant) -> ISSUE (drive memory) -> RESP (pulse response).
module mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [1:0]      req_we,
  input  logic [2*AW-1:0] req_addr,
  input  logic [2*DW-1:0] req_wdata,
  output logic [1:0]      resp_valid,
  output logic [DW-1:0]   resp_data,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_in,
  input  logic [DW-1:0]   mem_out
);

  // Handshake: a request transfers on a rising edge where req_valid[i] && req_ready[i];
  // the requester holds valid and payload stable until then, and ready is only offered in IDLE.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state, state_next;
  logic   last_grant;
  logic   owner;
  logic   gnt;
  logic   accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    gnt        = req_valid[1];
    req_ready  = 2'b00;
    resp_valid = 2'b00;
    state_next = state;
    // On a tie the port that did not win last time goes next.
    if (req_valid == 2'b11) gnt = ~last_grant;
    accept = (state == IDLE) && (req_valid != 2'b00);
    case (state)
      IDLE: begin
        if (accept) begin
          req_ready[gnt] = 1'b1;
          state_next     = ISSUE;
        end
      end
      ISSUE: state_next = RESP;
      RESP: begin
        resp_valid[owner] = 1'b1;
        state_next        = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      resp_data  <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_in     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner      <= gnt;
            last_grant <= gnt;
            mem_we     <= gnt ? req_we[1] : req_we[0];
            mem_addr   <= gnt ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
            mem_in     <= gnt ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
          end
        end
        ISSUE: begin
          resp_data <= mem_out;
          mem_we    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a write-through memory model and per-cycle invariants.
module tb_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      req_valid = '0;
  logic [1:0]      req_ready;
  logic [1:0]      req_we = '0;
  logic [2*AW-1:0] req_addr = '0;
  logic [2*DW-1:0] req_wdata = '0;
  logic [1:0]      resp_valid;
  logic [DW-1:0]   resp_data;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_in;
  logic [DW-1:0]   mem_out;

  logic [DW-1:0]   mem [256];
  int checks = 0;
  int errors = 0;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_in(mem_in), .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  // Memory: combinational read, write-through while we is high, write commits on posedge.
  assign mem_out = mem_we ? mem_in : mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [1:0] st;
    st = dut.state;
    if (!rst) begin
      if (st != ST_IDLE) chk("ready_outside_idle", {30'd0, req_ready}, 32'd0);
      chk("resp_onehot0", {31'd0, $onehot0(resp_valid)}, 32'd1);
      chk("ready_onehot0", {31'd0, $onehot0(req_ready)}, 32'd1);
      if (st != ST_ISSUE) chk("we_outside_issue", {31'd0, mem_we}, 32'd0);
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    // Reset state
    #12;
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {30'd0, resp_valid}, 32'd0);
    chk("rst_resp_data", {24'd0, resp_data}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    chk("rst_mem_in", {24'd0, mem_in}, 32'd0);
    tick();
    rst = 1'b0;

    // 1: port0 write addr0 = 10
    req_valid = 2'b01; req_we = 2'b01; req_addr = 16'h0000; req_wdata = 16'h000A;
    #1 chk("t1_ready", {30'd0, req_ready}, 32'd1);
    chk("t1_we_idle", {31'd0, mem_we}, 32'd0);
    tick();
    req_valid = 2'b00;
    chk("t1_we_issue", {31'd0, mem_we}, 32'd1);
    chk("t1_addr", {24'd0, mem_addr}, 32'd0);
    chk("t1_in", {24'd0, mem_in}, 32'd10);
    chk("t1_no_resp_issue", {30'd0, resp_valid}, 32'd0);
    tick();
    chk("t1_resp_valid", {30'd0, resp_valid}, 32'd1);
    chk("t1_resp_data", {24'd0, resp_data}, 32'd10);
    chk("t1_we_resp", {31'd0, mem_we}, 32'd0);
    tick();
    chk("t1_resp_done", {30'd0, resp_valid}, 32'd0);

    // 2: port1 read addr0
    req_valid = 2'b10; req_we = 2'b00; req_addr = 16'h0000;
    #1 chk("t2_ready", {30'd0, req_ready}, 32'd2);
    tick();
    req_valid = 2'b00;
    chk("t2_we_issue", {31'd0, mem_we}, 32'd0);
    tick();
    chk("t2_resp_valid", {30'd0, resp_valid}, 32'd2);
    chk("t2_resp_data", {24'd0, resp_data}, 32'd10);
    tick();

    // 3: both valid from reset, grants alternate 0,1,0,1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 2'b11; req_we = 2'b01; req_addr = 16'h0101; req_wdata = 16'h000B;
    for (int k = 0; k < 4; k++) begin
      #1 chk("t3_grant", {30'd0, req_ready}, (k % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      tick();
      chk("t3_resp_valid", {30'd0, resp_valid}, (k % 2 == 0) ? 32'd1 : 32'd2);
      chk("t3_resp_data", {24'd0, resp_data}, 32'd11);
      tick();
    end
    req_valid = 2'b00;
    tick();

    // 4: back-to-back port0 writes 12,13 to addr2, then read back
    req_valid = 2'b01; req_we = 2'b01; req_addr = 16'h0002; req_wdata = 16'h000C;
    #1 chk("t4_ready_a", {30'd0, req_ready}, 32'd1);
    tick();
    req_wdata = 16'h000D;
    chk("t4_busy_issue", {30'd0, req_ready}, 32'd0);
    tick();
    chk("t4_busy_resp", {30'd0, req_ready}, 32'd0);
    chk("t4_data_a", {24'd0, resp_data}, 32'd12);
    tick();
    chk("t4_ready_b", {30'd0, req_ready}, 32'd1);
    tick();
    req_valid = 2'b00;
    tick();
    chk("t4_data_b", {24'd0, resp_data}, 32'd13);
    tick();
    req_valid = 2'b01; req_we = 2'b00;
    #1 chk("t4_ready_rd", {30'd0, req_ready}, 32'd1);
    tick();
    req_valid = 2'b00;
    tick();
    chk("t4_rd_valid", {30'd0, resp_valid}, 32'd1);
    chk("t4_rd_data", {24'd0, resp_data}, 32'd13);
    tick();

    // 5: reset during ISSUE of a port0 write to addr3
    req_valid = 2'b01; req_we = 2'b01; req_addr = 16'h0003; req_wdata = 16'h002C;
    tick();
    req_valid = 2'b00;
    chk("t5_we_issue", {31'd0, mem_we}, 32'd1);
    rst = 1'b1;
    #1 chk("t5_we_dropped", {31'd0, mem_we}, 32'd0);
    chk("t5_no_resp", {30'd0, resp_valid}, 32'd0);
    chk("t5_mem_unwritten", {24'd0, mem[3]}, 32'd0);
    #1 rst = 1'b0;
    req_valid = 2'b11; req_we = 2'b00; req_addr = 16'h0303;
    #1 chk("t5_grant_p0", {30'd0, req_ready}, 32'd1);
    tick();
    req_valid = 2'b10;
    chk("t5_no_resp_issue", {30'd0, resp_valid}, 32'd0);
    tick();
    chk("t5_resp_valid", {30'd0, resp_valid}, 32'd1);
    chk("t5_resp_data", {24'd0, resp_data}, 32'd0);
    tick();
    #1 chk("t5_grant_p1", {30'd0, req_ready}, 32'd2);
    tick();
    req_valid = 2'b00;
    tick();
    chk("t5_p1_resp", {30'd0, resp_valid}, 32'd2);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
